// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with enable gating and direct, latched
// and self-timed scan (up/down, programmable dwell) operating modes.
module scan_decoder #(
  parameter int unsigned N_SEL      = 3,
  parameter int unsigned SCAN_DWELL = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [1:0]              mode_i,
  input  logic [N_SEL-1:0]        in_i,
  input  logic                    load_i,
  output logic [(2**N_SEL)-1:0]   out_o,
  output logic [N_SEL-1:0]        idx_o,
  output logic                    wrap_o
);

  localparam int unsigned OUT_W = 2 ** N_SEL;
  localparam int unsigned DW_W  = $clog2(SCAN_DWELL + 1);

  localparam logic [1:0] ModeDirect   = 2'b00;
  localparam logic [1:0] ModeScanUp   = 2'b01;
  localparam logic [1:0] ModeScanDown = 2'b10;
  localparam logic [1:0] ModeLatch    = 2'b11;

  typedef enum logic [1:0] {StIdle, StDirect, StScan, StLatch} state_e;

  state_e           state_q;
  logic [OUT_W-1:0] out_q;
  logic [N_SEL-1:0] idx_q;
  logic             wrap_q;
  logic [DW_W-1:0]  dwell_q;

  logic [N_SEL-1:0] scan_idx_d;
  logic             scan_wrap_d;
  logic             dwell_done;
  logic [OUT_W-1:0] in_onehot;
  logic [OUT_W-1:0] scan_onehot;

  // Next index for a scan step in the currently requested direction.
  always_comb begin
    scan_idx_d  = idx_q;
    scan_wrap_d = 1'b0;
    if (mode_i == ModeScanDown) begin
      scan_idx_d  = idx_q - N_SEL'(1);
      scan_wrap_d = (idx_q == '0);
    end else begin
      scan_idx_d  = idx_q + N_SEL'(1);
      scan_wrap_d = (idx_q == N_SEL'(OUT_W - 1));
    end
  end

  assign dwell_done  = (dwell_q == DW_W'(SCAN_DWELL - 1));
  assign in_onehot   = OUT_W'(1) << in_i;
  assign scan_onehot = OUT_W'(1) << scan_idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      out_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      dwell_q <= '0;
    end else begin
      wrap_q <= 1'b0;
      if (!en_i) begin
        state_q <= StIdle;
        out_q   <= '0;
        dwell_q <= '0;
      end else begin
        unique case (mode_i)
          ModeDirect: begin
            state_q <= StDirect;
            out_q   <= in_onehot;
            idx_q   <= in_i;
            dwell_q <= '0;
          end
          ModeLatch: begin
            state_q <= StLatch;
            dwell_q <= '0;
            if (load_i) begin
              out_q <= in_onehot;
              idx_q <= in_i;
            end
          end
          ModeScanUp, ModeScanDown: begin
            state_q <= StScan;
            if (state_q != StScan) begin
              // Fresh entry re-seeds from in; direction flips keep position.
              out_q   <= in_onehot;
              idx_q   <= in_i;
              dwell_q <= '0;
            end else if (dwell_done) begin
              out_q   <= scan_onehot;
              idx_q   <= scan_idx_d;
              wrap_q  <= scan_wrap_d;
              dwell_q <= '0;
            end else begin
              dwell_q <= dwell_q + DW_W'(1);
            end
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed vector table, hand sequences
// and randomized traffic against a cycle-count reference model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [1:0] mode;
  logic [2:0] sel;

  logic [7:0] out2, out1;
  logic [2:0] idx2, idx1;
  logic       wrap2, wrap1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  scan_decoder #(.N_SEL(3), .SCAN_DWELL(2)) u_dut2 (
    .clk_i (clk), .rst_i (rst), .en_i (en), .mode_i (mode), .in_i (sel), .load_i (load),
    .out_o (out2), .idx_o (idx2), .wrap_o (wrap2)
  );

  scan_decoder #(.N_SEL(3), .SCAN_DWELL(1)) u_dut1 (
    .clk_i (clk), .rst_i (rst), .en_i (en), .mode_i (mode), .in_i (sel), .load_i (load),
    .out_o (out1), .idx_o (idx1), .wrap_o (wrap1)
  );

  // Reference model, one slot per DUT: [0] dwell 2, [1] dwell 1.
  int m_idx[2], m_out[2], m_age[2];
  bit m_wrap[2], m_scan[2];

  task automatic model_edge(input int k);
    int d;
    d = (k == 0) ? 2 : 1;
    m_wrap[k] = 1'b0;
    if (rst) begin
      m_idx[k] = 0; m_out[k] = 0; m_age[k] = 0; m_scan[k] = 1'b0;
    end else if (!en) begin
      m_out[k] = 0; m_scan[k] = 1'b0;
    end else if (mode == 2'd0) begin
      m_idx[k] = int'(sel); m_out[k] = 2 ** int'(sel); m_scan[k] = 1'b0;
    end else if (mode == 2'd3) begin
      m_scan[k] = 1'b0;
      if (load) begin
        m_idx[k] = int'(sel); m_out[k] = 2 ** int'(sel);
      end
    end else if (!m_scan[k]) begin
      m_scan[k] = 1'b1; m_age[k] = 0;
      m_idx[k] = int'(sel); m_out[k] = 2 ** int'(sel);
    end else begin
      m_age[k] = m_age[k] + 1;
      if (m_age[k] == d) begin
        m_age[k] = 0;
        if (mode == 2'd1) begin
          m_idx[k]  = (m_idx[k] + 1) % 8;
          m_wrap[k] = (m_idx[k] == 0);
        end else begin
          m_idx[k]  = (m_idx[k] + 7) % 8;
          m_wrap[k] = (m_idx[k] == 7);
        end
        m_out[k] = 2 ** m_idx[k];
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic check_model();
    chk("model_out_d2", 32'(out2), 32'(m_out[0]));
    chk("model_idx_d2", 32'(idx2), 32'(m_idx[0]));
    chk("model_wrap_d2", 32'(wrap2), 32'(m_wrap[0]));
    chk("model_out_d1", 32'(out1), 32'(m_out[1]));
    chk("model_idx_d1", 32'(idx1), 32'(m_idx[1]));
    chk("model_wrap_d1", 32'(wrap1), 32'(m_wrap[1]));
    chk("onehot_d2", 32'((out2 == 8'h00) || (out2 == (8'h01 << idx2))), 32'd1);
    chk("onehot_d1", 32'((out1 == 8'h00) || (out1 == (8'h01 << idx1))), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [2:0] sel;
    logic       load;
    logic [7:0] out;
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic [2:0] s,
                     input logic l, input logic [7:0] o, input logic [2:0] i, input logic w);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sel = s; v.load = l;
    v.out = o; v.idx = i; v.wrap = w;
    vecs.push_back(v);
  endtask

  initial begin
    int wraps;
    rst = 1'b1; en = 1'b1; mode = 2'd0; sel = 3'd5; load = 1'b0;

    // Expectations for the dwell-2 instance, one row per clock edge.
    //   rst en mode sel load   out    idx  wrap
    add(1, 1, 0, 5, 0, 8'h00, 0, 0);  // reset dominates en/mode
    add(0, 1, 0, 5, 0, 8'h20, 5, 0);
    add(0, 0, 0, 5, 0, 8'h00, 5, 0);  // disable clears out, idx holds
    add(0, 1, 0, 7, 0, 8'h80, 7, 0);
    add(0, 1, 1, 6, 0, 8'h40, 6, 0);  // scan up seeded at 6
    add(0, 1, 1, 0, 0, 8'h40, 6, 0);  // in not re-sampled
    add(0, 1, 1, 0, 0, 8'h80, 7, 0);
    add(0, 1, 1, 0, 0, 8'h80, 7, 0);
    add(0, 1, 1, 0, 0, 8'h01, 0, 1);  // up wrap
    add(0, 1, 1, 0, 0, 8'h01, 0, 0);
    add(0, 1, 0, 1, 0, 8'h02, 1, 0);
    add(0, 1, 2, 1, 0, 8'h02, 1, 0);  // scan down seeded at 1
    add(0, 1, 2, 1, 0, 8'h02, 1, 0);
    add(0, 1, 2, 1, 0, 8'h01, 0, 0);
    add(0, 1, 2, 1, 0, 8'h01, 0, 0);
    add(0, 1, 2, 1, 0, 8'h80, 7, 1);  // down wrap
    add(0, 1, 1, 3, 0, 8'h80, 7, 0);  // flip to up mid-dwell
    add(0, 1, 1, 3, 0, 8'h01, 0, 1);  // steps up from 7, no re-seed
    add(0, 0, 1, 3, 0, 8'h00, 0, 0);
    add(0, 1, 3, 5, 0, 8'h00, 0, 0);  // latch from idle keeps zero
    add(0, 1, 3, 3, 1, 8'h08, 3, 0);
    add(0, 1, 3, 6, 0, 8'h08, 3, 0);
    add(0, 0, 3, 2, 1, 8'h00, 3, 0);  // disable beats load
    add(0, 1, 1, 4, 0, 8'h10, 4, 0);
    add(0, 1, 1, 4, 0, 8'h10, 4, 0);
    add(0, 1, 0, 2, 0, 8'h04, 2, 0);  // direct wins over a due step
    add(0, 1, 1, 4, 0, 8'h10, 4, 0);
    add(0, 1, 1, 4, 1, 8'h10, 4, 0);
    add(0, 1, 3, 1, 0, 8'h10, 4, 0);  // latch from scan holds out
    add(0, 1, 1, 4, 0, 8'h10, 4, 0);
    add(1, 1, 1, 4, 1, 8'h00, 0, 0);  // reset mid-scan
    add(0, 1, 1, 6, 0, 8'h40, 6, 0);

    foreach (vecs[n]) begin
      rst = vecs[n].rst; en = vecs[n].en; mode = vecs[n].mode;
      sel = vecs[n].sel; load = vecs[n].load;
      tick();
      chk($sformatf("vec%0d_out", n), 32'(out2), 32'(vecs[n].out));
      chk($sformatf("vec%0d_idx", n), 32'(idx2), 32'(vecs[n].idx));
      chk($sformatf("vec%0d_wrap", n), 32'(wrap2), 32'(vecs[n].wrap));
      check_model();
    end

    // Direct sweep, one cycle of latency.
    rst = 1'b0; en = 1'b1; mode = 2'd0; load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      tick();
      chk("direct_sweep", 32'(out2), 32'(8'h01 << i));
      chk("direct_popcount", 32'($countones(out2)), 32'd1);
    end

    // Dwell 1: step every cycle, two wraps across sixteen steps.
    rst = 1'b1; tick();
    rst = 1'b0; mode = 2'd1; sel = 3'd0; tick();
    chk("d1_seed", 32'(out1), 32'h01);
    wraps = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("d1_step", 32'(out1), 32'(8'h01 << (i % 8)));
      if (wrap1) wraps++;
    end
    chk("d1_wrap_count", 32'(wraps), 32'd2);

    // Randomized traffic; modes are sticky so scans get to run.
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 47) == 0);
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      sel  = 3'($urandom);
      load = ($urandom_range(0, 3) == 0);
      tick();
      check_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered binary-to-one-hot decoder: N_SEL-bit select in, 2**N_SEL-bit one-hot out.
- Adds enable gating and three operating modes:
  - direct decode
  - latched decode, updated only on a load strobe
  - self-timed scan up/down with a programmable dwell per output
- Drives chip-select, row-select and LED/digit-multiplex lines in the sub-block designs.
- All outputs are registered.

Parameters:
- N_SEL, 3, select width; OUT_W = 2**N_SEL is a derived localparam, not overridable.
- SCAN_DWELL, 4, cycles each output stays active in scan mode; legal range >= 1; 1 = step every cycle.
- DW_W, $clog2(SCAN_DWELL+1), dwell counter width; derived localparam.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable; low forces the output to all-zero.
- mode  in  2  00 direct, 01 scan up, 10 scan down, 11 latched.
- in  in  N_SEL  select value; also the scan start index and the latched-mode load value.
- load  in  1  latched-mode capture strobe; ignored in other modes.
- out  out  OUT_W  registered one-hot output, or all-zero.
- idx  out  N_SEL  registered binary index of the active output bit.
- wrap  out  1  one-cycle pulse on scan wrap-around.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: out = 0, idx = 0, wrap = 0, dwell counter = 0, state = IDLE.
- Priority per edge: rst > en = 0 > mode.
- Invariant: out is either all-zero or exactly 1 << idx. It is never multi-hot.
- wrap defaults to 0 on every edge unless a scan step wraps.
- States: IDLE, DIRECT, SCAN, LATCH.
- IDLE:
  - Entered on rst, or on any edge with en = 0, from any state.
  - out <= 0; idx holds; dwell counter <= 0.
  - Leaves on the first edge with en = 1, to the state selected by mode.
- DIRECT (mode 00):
  - Each edge: out <= 1 << in; idx <= in.
  - Latency 1 cycle from in to out.
- SCAN, entry (mode 01 or 10, from any non-SCAN state):
  - idx <= in; out <= 1 << in; dwell counter <= 0.
  - The first output therefore holds for SCAN_DWELL cycles.
- SCAN, running:
  - Dwell counter increments each edge.
  - When the counter = SCAN_DWELL-1: counter <= 0 and idx steps.
    - Up: idx+1 mod OUT_W.
    - Down: idx-1 mod OUT_W.
  - out follows the new idx on the same edge.
- SCAN, wrap:
  - wrap <= 1 for exactly one cycle, coincident with out showing the wrapped index.
  - Up wrap: idx steps OUT_W-1 -> 0.
  - Down wrap: idx steps 0 -> OUT_W-1.
- SCAN, direction change (01 <-> 10 while in SCAN):
  - State stays SCAN; idx and dwell counter are kept; in is NOT re-sampled.
  - The next step uses the new direction.
- LATCH (mode 11):
  - On entry, out and idx hold their current values; from IDLE, out stays 0.
  - load = 1 on an edge: out <= 1 << in; idx <= in.
  - load = 0: hold.
- Mode change to DIRECT or LATCH mid-scan:
  - Takes effect on the next edge.
  - Dwell counter cleared; no wrap pulse is generated.
- en deasserted mid-scan:
  - Next edge: out = 0.
  - Re-enable with a scan mode re-seeds from in; there is no resume.
- Reset mid-operation: all state returns to the reset values on that edge, regardless of en, mode or load.
- Width rules:
  - Index arithmetic is N_SEL bits with natural modulo wrap.
  - Shifts are OUT_W bits wide; no X may appear on out for any in value.

Test Plan (N_SEL = 3, SCAN_DWELL = 2 unless stated):
- Reset and enable: rst = 1 with en = 1, mode = 00, in = 5 -> out = 0x00, idx = 0, wrap = 0. Release rst -> out = 0x20 one edge later. Then en = 0 -> out = 0x00 next edge.
- Direct sweep: in = 0..7 over consecutive cycles -> out = 0x01..0x80, each one cycle late. popcount(out) == 1 always.
- Scan up with wrap: mode = 01, in = 6 -> out sequence 0x40, 0x40, 0x80, 0x80, 0x01. wrap = 1 only in the first 0x01 cycle.
- Scan down and direction flip: mode = 10, in = 1 -> out 0x02, 0x02, 0x01, 0x01, 0x80 with wrap pulse. Then switch to 01 mid-dwell -> next step goes to 0x01 with no re-seed.
- Latched mode: mode = 11 from IDLE -> out = 0x00. load = 1, in = 3 -> out = 0x08. in changes with load = 0 -> out stays 0x08. Simultaneous load = 1 and en = 0 -> out = 0x00.
- Reset mid-scan and SCAN_DWELL = 1: rst pulse during scan -> all outputs zero next edge. With SCAN_DWELL = 1 and mode = 01 -> out steps every cycle, wrap once per 8 cycles.
